// File: rtl/bus_line_monitor_pkg.sv
// rtl/bus_line_monitor_pkg.sv - shared widths, timing types and bus event classification
package bus_line_monitor_pkg;

    localparam int FILTER_W_DEF = 4;
    localparam int IDLE_W_DEF   = 20;

    typedef logic [FILTER_W_DEF-1:0] filter_cnt_t;
    typedef logic [IDLE_W_DEF-1:0]   idle_cnt_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } bus_event_e;

    // SDA may only signal a condition while SCL is high and not itself moving.
    function automatic bus_event_e classify_event(
        input logic scl_level,
        input logic scl_rise,
        input logic scl_fall,
        input logic sda_rise,
        input logic sda_fall
    );
        if (!scl_level || scl_rise || scl_fall) begin
            return EV_NONE;
        end
        if (sda_fall) begin
            return EV_START;
        end
        if (sda_rise) begin
            return EV_STOP;
        end
        return EV_NONE;
    endfunction

endpackage

// File: rtl/bus_line_monitor_line_filter.sv
// rtl/bus_line_monitor_line_filter.sv - pad synchroniser, stable-count spike filter and edge pulses
module bus_line_monitor_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                line_i,
    input  logic [FILTER_W-1:0] t_filter_i,
    output logic                filt_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                rise_pulse_o,
    output logic                fall_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTER_W-1:0]    cnt_q;
    logic                   sync;
    logic                   accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // rise_o/fall_o announce the change filt_o takes at the coming edge,
    // so the top can register START/STOP in step with the edge pulses.
    assign accept = enable_i && (sync != filt_o) && (cnt_q >= t_filter_i);
    assign rise_o = accept && sync;
    assign fall_o = accept && !sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            filt_o       <= 1'b1;
            rise_pulse_o <= 1'b0;
            fall_pulse_o <= 1'b0;
        end else begin
            rise_pulse_o <= rise_o;
            fall_pulse_o <= fall_o;
            if (!enable_i) begin
                cnt_q  <= '0;
                filt_o <= sync;
            end else if (sync == filt_o) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q  <= '0;
                filt_o <= sync;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_line_monitor.sv
// rtl/bus_line_monitor.sv - SCL/SDA receive front end with START/STOP, busy and idle detection
module bus_line_monitor
    import bus_line_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = FILTER_W_DEF,
    parameter int IDLE_W      = IDLE_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                scl_i,
    input  logic                sda_i,
    input  logic [FILTER_W-1:0] t_filter_i,
    input  logic [IDLE_W-1:0]   t_idle_i,
    output logic                scl_o,
    output logic                sda_o,
    output logic                scl_posedge_o,
    output logic                scl_negedge_o,
    output logic                sda_posedge_o,
    output logic                sda_negedge_o,
    output logic                start_det_o,
    output logic                rstart_det_o,
    output logic                stop_det_o,
    output logic                bus_busy_o,
    output logic                bus_idle_o
);

    logic        scl_rise, scl_fall, sda_rise, sda_fall;
    logic [IDLE_W-1:0] idle_cnt;
    bus_event_e  ev;

    bus_line_monitor_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W)
    ) u_scl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .line_i       (scl_i),
        .t_filter_i   (t_filter_i),
        .filt_o       (scl_o),
        .rise_o       (scl_rise),
        .fall_o       (scl_fall),
        .rise_pulse_o (scl_posedge_o),
        .fall_pulse_o (scl_negedge_o)
    );

    bus_line_monitor_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W)
    ) u_sda (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .line_i       (sda_i),
        .t_filter_i   (t_filter_i),
        .filt_o       (sda_o),
        .rise_o       (sda_rise),
        .fall_o       (sda_fall),
        .rise_pulse_o (sda_posedge_o),
        .fall_pulse_o (sda_negedge_o)
    );

    assign ev = classify_event(scl_o, scl_rise, scl_fall, sda_rise, sda_fall);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_det_o  <= 1'b0;
            rstart_det_o <= 1'b0;
            stop_det_o   <= 1'b0;
            bus_busy_o   <= 1'b0;
        end else begin
            start_det_o  <= (ev == EV_START) && !bus_busy_o;
            rstart_det_o <= (ev == EV_START) && bus_busy_o;
            stop_det_o   <= (ev == EV_STOP);
            if (!enable_i) begin
                bus_busy_o <= 1'b0;
            end else if (ev == EV_START) begin
                bus_busy_o <= 1'b1;
            end else if (ev == EV_STOP) begin
                bus_busy_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt   <= '0;
            bus_idle_o <= 1'b0;
        end else begin
            if (!enable_i || !scl_o || !sda_o) begin
                idle_cnt <= '0;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            bus_idle_o <= enable_i && scl_o && sda_o && (idle_cnt >= t_idle_i);
        end
    end

endmodule

// File: tb/tb_bus_line_monitor.sv
// tb/tb_bus_line_monitor.sv - scoreboard bench for bus_line_monitor against a line-history model
module tb_bus_line_monitor;
    import bus_line_monitor_pkg::*;

    localparam int SYNC = 2;
    localparam logic [10:0] RESET_VEC  = 11'b110_0000_0000;
    localparam logic [10:0] PULSE_MASK = 11'b001_1111_1100;

    logic        clk;
    logic        rst_ni;
    logic        enable_i;
    logic        scl_i, sda_i;
    filter_cnt_t t_filter_i;
    idle_cnt_t   t_idle_i;
    logic scl_o, sda_o, scl_posedge_o, scl_negedge_o, sda_posedge_o, sda_negedge_o;
    logic start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o;

    bus_line_monitor #(
        .SYNC_STAGES (SYNC),
        .FILTER_W    (FILTER_W_DEF),
        .IDLE_W      (IDLE_W_DEF)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .scl_i         (scl_i),
        .sda_i         (sda_i),
        .t_filter_i    (t_filter_i),
        .t_idle_i      (t_idle_i),
        .scl_o         (scl_o),
        .sda_o         (sda_o),
        .scl_posedge_o (scl_posedge_o),
        .scl_negedge_o (scl_negedge_o),
        .sda_posedge_o (sda_posedge_o),
        .sda_negedge_o (sda_negedge_o),
        .start_det_o   (start_det_o),
        .rstart_det_o  (rstart_det_o),
        .stop_det_o    (stop_det_o),
        .bus_busy_o    (bus_busy_o),
        .bus_idle_o    (bus_idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_start_seen = 0, n_rstart_seen = 0, n_stop_seen = 0, n_sda_neg_seen = 0;

    // Reference model: pads delayed through the synchroniser, a filtered line
    // that flips once its last t+1 samples all disagree with it, and event rules
    // applied to the filtered lines.
    bit pipe [2][SYNC];
    bit hist [2][16];
    bit m_filt [2];
    bit m_busy;
    int m_run;

    function automatic void model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < SYNC; i++) pipe[l][i] = 1'b1;
            for (int i = 0; i < 16; i++) hist[l][i] = 1'b1;
            m_filt[l] = 1'b1;
        end
        m_busy = 1'b0;
        m_run  = 0;
    endfunction

    function automatic logic [10:0] model_step(input bit scl_pad, input bit sda_pad,
                                               input bit en, input int tf, input int ti);
        bit pad [2];
        bit old [2];
        bit rose [2];
        bit fell [2];
        bit s, all_diff, idle, start, stop, scl_still;
        pad[0] = scl_pad;
        pad[1] = sda_pad;
        if (en && m_filt[0] && m_filt[1]) m_run++;
        else m_run = 0;
        idle = (m_run > ti);
        for (int l = 0; l < 2; l++) begin
            s = pipe[l][SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) pipe[l][i] = pipe[l][i-1];
            pipe[l][0] = pad[l];
            for (int i = 0; i < 15; i++) hist[l][i] = hist[l][i+1];
            hist[l][15] = s;
            old[l] = m_filt[l];
            if (!en) begin
                m_filt[l] = s;
            end else begin
                all_diff = 1'b1;
                for (int k = 0; k <= tf; k++) if (hist[l][15-k] == m_filt[l]) all_diff = 1'b0;
                if (all_diff) m_filt[l] = s;
            end
            rose[l] = en && !old[l] && m_filt[l];
            fell[l] = en && old[l] && !m_filt[l];
        end
        scl_still = old[0] && !rose[0] && !fell[0];
        start = scl_still && fell[1];
        stop  = scl_still && rose[1];
        model_step = {m_filt[0], m_filt[1], rose[0], fell[0], rose[1], fell[1],
                      start && !m_busy, start && m_busy, stop, 1'b0, idle};
        if (!en) m_busy = 1'b0;
        else if (start) m_busy = 1'b1;
        else if (stop) m_busy = 1'b0;
        model_step[1] = m_busy;
    endfunction

    function automatic logic [10:0] out_vec();
        return {scl_o, sda_o, scl_posedge_o, scl_negedge_o, sda_posedge_o, sda_negedge_o,
                start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input bit scl_v, input bit sda_v);
        exp_t e;
        scl_i = scl_v;
        sda_i = sda_v;
        e.v   = model_step(scl_v, sda_v, enable_i, int'(t_filter_i), int'(t_idle_i));
        e.cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic hold(input int n, input bit s, input bit d);
        for (int i = 0; i < n; i++) drive_cycle(s, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, p0, n0;
        bit rs, rd, rsda;
        exp_t e;
        rst_ni     = 1'b0;
        enable_i   = 1'b1;
        scl_i      = 1'b1;
        sda_i      = 1'b1;
        t_filter_i = '0;
        t_idle_i   = idle_cnt_t'(5);
        model_reset();

        fork
            forever begin
                @(negedge clk);
                n_start_seen   += int'(start_det_o);
                n_rstart_seen  += int'(rstart_det_o);
                n_stop_seen    += int'(stop_det_o);
                n_sda_neg_seen += int'(sda_negedge_o);
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_vec() !== e.v || e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL scoreboard cyc=%0d exp_cyc=%0d got=%b expected=%b",
                                 cyc, e.cyc, out_vec(), e.v);
                    end
                end
            end
        join_none

        // Reset and first idle declaration.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_outputs", int'(out_vec()), int'(RESET_VEC));
        rst_ni = 1'b1;
        hold(5, 1, 1);
        check("idle_not_yet", int'(bus_idle_o), 0);
        hold(2, 1, 1);
        check("idle_after_reset", int'(bus_idle_o), 1);

        // Spike filter with t_filter=3.
        t_filter_i = filter_cnt_t'(3);
        hold(4, 1, 1);
        n0 = n_sda_neg_seen;
        hold(3, 1, 0);
        hold(8, 1, 1);
        check("glitch3_suppressed", n_sda_neg_seen - n0, 0);
        n0 = n_sda_neg_seen;
        hold(4, 1, 0);
        hold(1, 1, 1);
        check("low4_not_before_6", int'(sda_o), 1);
        hold(1, 1, 1);
        check("low4_at_6", int'(sda_o), 0);
        check("low4_negedge_at_6", int'(sda_negedge_o), 1);
        hold(8, 1, 1);
        check("low4_single_negedge", n_sda_neg_seen - n0, 1);

        // START, repeated START, STOP with t_filter=0.
        t_filter_i = '0;
        hold(4, 1, 1);
        s0 = n_start_seen; r0 = n_rstart_seen; p0 = n_stop_seen;
        hold(4, 1, 0);
        hold(4, 0, 0);
        check("busy_after_start", int'(bus_busy_o), 1);
        hold(4, 0, 1);
        hold(4, 1, 1);
        hold(4, 1, 0);
        check("busy_after_rstart", int'(bus_busy_o), 1);
        hold(4, 1, 1);
        check("busy_after_stop", int'(bus_busy_o), 0);
        check("start_count", n_start_seen - s0, 1);
        check("rstart_count", n_rstart_seen - r0, 1);
        check("stop_count", n_stop_seen - p0, 1);

        // Simultaneous fall of both lines.
        hold(3, 0, 0);
        check("simul_scl_neg", int'(scl_negedge_o), 1);
        check("simul_sda_neg", int'(sda_negedge_o), 1);
        check("simul_no_start", int'(start_det_o), 0);
        check("simul_not_busy", int'(bus_busy_o), 0);
        hold(4, 1, 1);

        // Idle timing after a STOP, then a one-cycle SCL dip.
        t_idle_i = idle_cnt_t'(10);
        hold(4, 1, 0);
        hold(3, 1, 1);
        check("stop_before_idle", int'(stop_det_o), 1);
        hold(10, 1, 1);
        check("idle_at_13", int'(bus_idle_o), 0);
        hold(1, 1, 1);
        check("idle_at_14", int'(bus_idle_o), 1);
        hold(1, 0, 1);
        hold(2, 1, 1);
        check("idle_before_dip", int'(bus_idle_o), 1);
        hold(1, 1, 1);
        check("idle_dropped", int'(bus_idle_o), 0);
        hold(10, 1, 1);
        check("idle_restart_early", int'(bus_idle_o), 0);
        hold(1, 1, 1);
        check("idle_restart", int'(bus_idle_o), 1);

        // Disable mid-transfer.
        hold(4, 1, 0);
        check("busy_before_disable", int'(bus_busy_o), 1);
        enable_i = 1'b0;
        hold(1, 1, 0);
        check("disable_clears_busy", int'(bus_busy_o), 0);
        check("disable_no_pulses", int'(out_vec() & PULSE_MASK), 0);
        hold(3, 1, 0);
        enable_i = 1'b1;
        hold(4, 1, 1);

        // Asynchronous reset in the middle of a byte.
        hold(4, 1, 0);
        hold(3, 0, 0);
        rsda   = 1'($urandom_range(0, 1));
        scl_i  = 1'b0;
        sda_i  = rsda;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", int'(out_vec()), int'(RESET_VEC));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
        model_reset();
        s0 = n_start_seen; r0 = n_rstart_seen;
        hold(6, 0, rsda);
        check("no_start_after_reset", (n_start_seen - s0) + (n_rstart_seen - r0), 0);
        hold(4, 1, 1);

        // Randomised traffic, glitches and occasional disables.
        rs = 1'b1;
        rd = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            t_filter_i = filter_cnt_t'($urandom_range(0, 3));
            t_idle_i   = idle_cnt_t'($urandom_range(0, 12));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 4) == 0) rs = ~rs;
                if ($urandom_range(0, 4) == 0) rd = ~rd;
                enable_i = ($urandom_range(0, 39) != 0);
                drive_cycle(rs, rd);
            end
        end
        enable_i = 1'b1;
        hold(6, 1, 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
